// File: rtl/eth_mdio_phy.sv
// -----------------------------------------------------------------------------
// eth_mdio_phy
//   Clause-22 MDIO management responder (PHY side). It holds a 32 x 16-bit PHY
//   register file, answers read frames, and accepts write frames. Every accepted
//   MDIO write is also reported to local logic. MDIO is sampled and driven on
//   the rising edge of Clk (MDC).
//
// Ports
//   Clk            MDC clock; all logic runs on its rising edge
//   Rst            synchronous active-high reset
//   MDIO           bidirectional management data; driven only while Mdio_Oe=1
//   Loc_Wr_En      local register write strobe (status updates such as link)
//   Loc_Wr_Addr    local write address
//   Loc_Wr_Data    local write data
//   Mdio_Wr_Strobe 1-cycle pulse after an MDIO write frame completes
//   Mdio_Wr_Addr   register address of that write (held between strobes)
//   Mdio_Wr_Data   data of that write (held between strobes)
//   Frame_Err      1-cycle pulse when a malformed frame is aborted
//   Mdio_Oe        tristate enable of MDIO (exported for debug)
//
// Strobe semantics: Mdio_Wr_Strobe is a single-cycle event with no back
// pressure. Mdio_Wr_Addr/Mdio_Wr_Data are valid in the strobe cycle and remain
// stable until the next strobe.
// -----------------------------------------------------------------------------
module eth_mdio_phy #(
  parameter logic [4:0]  pPhy_Addr     = 5'd1,
  parameter int          pPreamble_Len = 32,
  parameter logic [31:0] pRO_Mask      = 32'h0000_000E,
  parameter logic [15:0] pPhy_Id1      = 16'h0007,
  parameter logic [15:0] pPhy_Id2      = 16'hC0F1
) (
  input  logic        Clk,
  input  logic        Rst,
  inout  wire         MDIO,
  input  logic        Loc_Wr_En,
  input  logic [4:0]  Loc_Wr_Addr,
  input  logic [15:0] Loc_Wr_Data,
  output logic        Mdio_Wr_Strobe,
  output logic [4:0]  Mdio_Wr_Addr,
  output logic [15:0] Mdio_Wr_Data,
  output logic        Frame_Err,
  output logic        Mdio_Oe
);

  localparam int PCW = $clog2(pPreamble_Len + 1);
  localparam logic [PCW-1:0] PRE_MAX = PCW'(pPreamble_Len);

  typedef enum logic [3:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD,
    S_TA_RD, S_TA_WR, S_DATA_RD, S_DATA_WR, S_SKIP
  } state_t;

  function automatic logic [15:0] reg_reset(input int idx);
    case (idx)
      0:       reg_reset = 16'h3100;
      1:       reg_reset = 16'h7809;
      2:       reg_reset = pPhy_Id1;
      3:       reg_reset = pPhy_Id2;
      default: reg_reset = 16'h0000;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [4:0]     data_cnt_q, data_cnt_d;
  logic           op_rd_q, op_rd_d;
  logic [4:0]     phyad_q, phyad_d;
  logic [4:0]     regad_q, regad_d;
  logic [15:0]    shift_q, shift_d;
  logic           oe_q, oe_d;
  logic           mdio_out_q, mdio_out_d;
  logic           wr_stb_q, wr_stb_d;
  logic [4:0]     wr_addr_q, wr_addr_d;
  logic [15:0]    wr_data_q, wr_data_d;
  logic           frame_err_q, frame_err_d;
  logic           soft_rst_q, soft_rst_d;
  logic [15:0]    regs_q [32];
  logic [15:0]    regs_d [32];

  logic           mdio_in;
  logic [4:0]     regad_next;
  logic [15:0]    wr_word;
  logic [15:0]    rd_val;

  assign mdio_in    = MDIO;
  assign MDIO       = oe_q ? mdio_out_q : 1'bz;
  assign regad_next = {regad_q[3:0], mdio_in};
  assign wr_word    = {shift_q[14:0], mdio_in};
  // Soft-reset bit of reg0 is self-clearing from the reader's point of view.
  assign rd_val     = regs_q[regad_next] & ((regad_next == 5'd0) ? 16'h7FFF : 16'hFFFF);

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    data_cnt_d  = data_cnt_q;
    op_rd_d     = op_rd_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    shift_d     = shift_q;
    oe_d        = oe_q;
    mdio_out_d  = mdio_out_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    soft_rst_d  = 1'b0;
    regs_d      = regs_q;

    case (state_q)
      S_IDLE: begin
        if (mdio_in) begin
          if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 1'b1;
        end else begin
          // A full preamble followed by a 0 means this 0 is ST bit 1.
          if (pre_cnt_q == PRE_MAX) state_d = S_ST;
          pre_cnt_d = '0;
        end
      end
      S_ST: begin
        bit_cnt_d = '0;
        if (mdio_in) state_d = S_OP;
        else begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_OP: begin
        if (bit_cnt_q == 3'd0) begin
          op_rd_d   = mdio_in;          // first bit 1 -> read (10)
          bit_cnt_d = 3'd1;
        end else if (op_rd_q != mdio_in) begin
          bit_cnt_d = '0;
          state_d   = S_PHYAD;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_PHYAD: begin
        phyad_d = {phyad_q[3:0], mdio_in};
        if (bit_cnt_q == 3'd4) begin
          bit_cnt_d = '0;
          state_d   = S_REGAD;
        end else bit_cnt_d = bit_cnt_q + 1'b1;
      end
      S_REGAD: begin
        regad_d = regad_next;
        if (bit_cnt_q == 3'd4) begin
          bit_cnt_d  = '0;
          data_cnt_d = '0;
          if (phyad_q != pPhy_Addr) state_d = S_SKIP;
          else if (op_rd_q) begin
            shift_d = rd_val;
            state_d = S_TA_RD;
          end else state_d = S_TA_WR;
        end else bit_cnt_d = bit_cnt_q + 1'b1;
      end
      S_TA_RD: begin
        // Take the line at the edge sampling TA bit 1: 0 is on the wire for TA bit 2.
        oe_d       = 1'b1;
        mdio_out_d = 1'b0;
        data_cnt_d = '0;
        state_d    = S_DATA_RD;
      end
      S_DATA_RD: begin
        if (data_cnt_q == 5'd16) begin
          oe_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          mdio_out_d = shift_q[15];
          shift_d    = {shift_q[14:0], 1'b0};
          data_cnt_d = data_cnt_q + 1'b1;
        end
      end
      S_TA_WR: begin
        if (bit_cnt_q == 3'd0) begin
          if (mdio_in) bit_cnt_d = 3'd1;
          else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else if (!mdio_in) begin
          data_cnt_d = '0;
          state_d    = S_DATA_WR;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DATA_WR: begin
        shift_d = wr_word;
        if (data_cnt_q == 5'd15) begin
          wr_stb_d  = 1'b1;
          wr_addr_d = regad_q;
          wr_data_d = wr_word;
          if (!pRO_Mask[regad_q]) begin
            regs_d[regad_q] = wr_word;
            if (regad_q == 5'd0 && wr_word[15]) soft_rst_d = 1'b1;
          end
          state_d = S_IDLE;
        end else data_cnt_d = data_cnt_q + 1'b1;
      end
      S_SKIP: begin
        // Another PHY owns TA + 16 data bits; stay off the line.
        if (data_cnt_q == 5'd17) state_d = S_IDLE;
        else data_cnt_d = data_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Local update is applied last so it wins an address collision.
    if (Loc_Wr_En) regs_d[Loc_Wr_Addr] = Loc_Wr_Data;

    if (soft_rst_q) begin
      for (int i = 0; i < 32; i++) regs_d[i] = reg_reset(i);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      data_cnt_q  <= '0;
      op_rd_q     <= 1'b0;
      phyad_q     <= '0;
      regad_q     <= '0;
      shift_q     <= '0;
      oe_q        <= 1'b0;
      mdio_out_q  <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      soft_rst_q  <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= reg_reset(i);
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      data_cnt_q  <= data_cnt_d;
      op_rd_q     <= op_rd_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      shift_q     <= shift_d;
      oe_q        <= oe_d;
      mdio_out_q  <= mdio_out_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      soft_rst_q  <= soft_rst_d;
      regs_q      <= regs_d;
    end
  end

  assign Mdio_Wr_Strobe = wr_stb_q;
  assign Mdio_Wr_Addr   = wr_addr_q;
  assign Mdio_Wr_Data   = wr_data_q;
  assign Frame_Err      = frame_err_q;
  assign Mdio_Oe        = oe_q;

endmodule
